// File: rtl/dut_run_sequencer.sv
// dut_run_sequencer: run/busy handshake initiator with SRAM readback stream; GOLDEN_CMP_EN adds golden compare
module dut_run_sequencer #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_WIDTH    = 32,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] num_results,
  output logic                  seq_busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  dut_run,
  input  logic                  dut_busy,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [CNT_WIDTH-1:0]  compute_cycles
`ifdef GOLDEN_CMP_EN
  ,
  output logic [ADDR_WIDTH-1:0] gold_address,
  input  logic [DATA_WIDTH-1:0] gold_data,
  output logic [ADDR_WIDTH-1:0] match_count
`endif
);
  typedef enum logic [2:0] {IDLE, WAIT_IDLE, RUN_REQ, WAIT_DONE, READ, FINISH} state_t;
  localparam int WW = $clog2(BUSY_TIMEOUT + 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] base_q, num_q, n_iss, n_acc, addr_q;
  logic [WW-1:0] wd;
  logic [DATA_WIDTH-1:0] fifo_d [2];
  logic wp, rp, inflight, start_acc, wait_st, to_hit, issue, pop, last_pop;
  logic [1:0] cnt, occ;
  assign start_acc = state == IDLE && start;
  assign wait_st = state inside {WAIT_IDLE, RUN_REQ, WAIT_DONE};
  assign to_hit = wait_st && wd == WW'(BUSY_TIMEOUT);
  assign res_valid = cnt != 2'd0;
  assign res_data = fifo_d[rp];
  assign pop = res_valid && res_ready;
  assign last_pop = pop && n_acc == num_q - ADDR_WIDTH'(1);
  // occupancy after this cycle's pop plus the read whose data lands this cycle
  assign occ = cnt + 2'(inflight) - 2'(pop);
  assign issue = state == READ && n_iss != num_q && occ < 2'd2;
  assign rd_address = issue ? base_q + n_iss : addr_q;
  assign seq_busy = state != IDLE;
  assign done = state == FINISH;
  // state register
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  // next-state logic; watchdog expiry wins over handshake progress
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? WAIT_IDLE : IDLE;
      WAIT_IDLE: state_nx = to_hit ? FINISH : dut_busy ? WAIT_IDLE : RUN_REQ;
      RUN_REQ:   state_nx = to_hit ? FINISH : dut_busy ? WAIT_DONE : RUN_REQ;
      WAIT_DONE: state_nx = to_hit ? FINISH : dut_busy ? WAIT_DONE : num_q == '0 ? FINISH : READ;
      READ:      state_nx = last_pop ? FINISH : READ;
      FINISH:    state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  // watchdog, run request, cycle counter, readback counters and result FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      wd <= '0;
      dut_run <= 1'b0;
      timeout_err <= 1'b0;
      base_q <= '0;
      num_q <= '0;
      compute_cycles <= '0;
      n_iss <= '0;
      n_acc <= '0;
      addr_q <= '0;
      inflight <= 1'b0;
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      fifo_d[0] <= '0;
      fifo_d[1] <= '0;
    end else begin
      wd <= state_nx != state ? '0 : wait_st ? wd + WW'(1) : wd;
      dut_run <= state_nx == RUN_REQ;
      timeout_err <= start_acc ? 1'b0 : to_hit ? 1'b1 : timeout_err;
      base_q <= start_acc ? base_addr : base_q;
      num_q <= start_acc ? num_results : num_q;
      compute_cycles <= state == WAIT_IDLE && state_nx == RUN_REQ ? '0 :
                        (state == RUN_REQ || (state == WAIT_DONE && dut_busy)) && !(&compute_cycles) ?
                        compute_cycles + CNT_WIDTH'(1) : compute_cycles;
      n_iss <= start_acc ? '0 : issue ? n_iss + ADDR_WIDTH'(1) : n_iss;
      n_acc <= start_acc ? '0 : pop ? n_acc + ADDR_WIDTH'(1) : n_acc;
      addr_q <= rd_address;
      inflight <= issue;
      cnt <= cnt + 2'(inflight) - 2'(pop);
      if (inflight) fifo_d[wp] <= rd_data;
      wp <= wp ^ inflight;
      rp <= rp ^ pop;
    end
  end
`ifdef GOLDEN_CMP_EN
  logic [DATA_WIDTH-1:0] gold_d [2];
  assign gold_address = rd_address;
  // golden words ride alongside results; count pops whose result equals its golden word
  always_ff @(posedge clk) begin
    if (reset) begin
      gold_d[0] <= '0;
      gold_d[1] <= '0;
      match_count <= '0;
    end else begin
      if (inflight) gold_d[wp] <= gold_data;
      match_count <= start_acc ? '0 : pop && res_data == gold_d[rp] ? match_count + ADDR_WIDTH'(1) : match_count;
    end
  end
`endif
endmodule

// File: tb/tb_dut_run_sequencer.sv
// tb_dut_run_sequencer: scoreboard bench for dut_run_sequencer
module tb_dut_run_sequencer;
  localparam int AW = 12, DW = 16, CW = 32;
  logic clk = 0, reset = 1, start = 0, dut_busy = 0, res_ready = 0;
  logic [AW-1:0] base_addr = '0, num_results = '0, rd_address;
  logic [DW-1:0] rd_data = '0, res_data;
  logic seq_busy, done, timeout_err, dut_run, res_valid;
  logic [CW-1:0] compute_cycles;
  logic t_start = 0, t_seq_busy, t_done, t_timeout_err, t_dut_run, t_res_valid;
  logic [AW-1:0] t_base = '0, t_num = '0, t_rd_address;
  logic [DW-1:0] t_rd_data = '0, t_res_data;
  logic [CW-1:0] t_compute_cycles;
  logic [DW-1:0] exp_q[$];
  int checks = 0, errors = 0, pops = 0, cyc = 0, first_pop = 0, last_pop = 0;
`ifdef GOLDEN_CMP_EN
  logic [AW-1:0] gold_address, match_count, t_gold_address, t_match_count, gold_bad = '0;
  logic [DW-1:0] gold_data = '0, t_gold_data = '0;
  logic gold_bad_en = 0;
`endif

  dut_run_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_results(num_results),
    .seq_busy(seq_busy), .done(done), .timeout_err(timeout_err), .dut_run(dut_run), .dut_busy(dut_busy),
    .rd_address(rd_address), .rd_data(rd_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .compute_cycles(compute_cycles)
`ifdef GOLDEN_CMP_EN
    , .gold_address(gold_address), .gold_data(gold_data), .match_count(match_count)
`endif
  );

  dut_run_sequencer #(.BUSY_TIMEOUT(16)) u_to (
    .clk(clk), .reset(reset), .start(t_start), .base_addr(t_base), .num_results(t_num),
    .seq_busy(t_seq_busy), .done(t_done), .timeout_err(t_timeout_err), .dut_run(t_dut_run), .dut_busy(1'b0),
    .rd_address(t_rd_address), .rd_data(t_rd_data), .res_valid(t_res_valid), .res_ready(1'b1),
    .res_data(t_res_data), .compute_cycles(t_compute_cycles)
`ifdef GOLDEN_CMP_EN
    , .gold_address(t_gold_address), .gold_data(t_gold_data), .match_count(t_match_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return DW'({4'h0, a} * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // synchronous-read output SRAM models
  always @(posedge clk) rd_data <= mem_f(rd_address);
`ifdef GOLDEN_CMP_EN
  always @(posedge clk) gold_data <= (gold_bad_en && gold_address == gold_bad) ? ~mem_f(gold_address) : mem_f(gold_address);
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: compare every accepted word with the oldest expected word
  always @(negedge clk)
    if (!reset && res_valid && res_ready) begin
      if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
      else check("res_data", res_data, exp_q.pop_front());
      if (pops == 0) first_pop = cyc;
      last_pop = cyc;
      pops++;
    end

  task automatic start_round(input logic [AW-1:0] b, input logic [AW-1:0] n);
    logic [AW-1:0] a;
    base_addr = b;
    num_results = n;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      exp_q.push_back(mem_f(a));
    end
    start = 1;
    step();
    start = 0;
    base_addr = 12'h5A5;
    num_results = 12'h00F;
  endtask

  task automatic busy_model(input int dly, input int hold);
    int k = 0;
    while (!dut_run && k < 300) begin
      step();
      k++;
    end
    check("run_rise", dut_run, 1);
    repeat (dly) begin
      check("run_hold", dut_run, 1);
      step();
    end
    dut_busy = 1;
    step();
    check("run_drop", dut_run, 0);
    repeat (hold - 1) step();
    dut_busy = 0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done && k < bound) begin
      step();
      k++;
    end
    check("done_seen", done, 1);
    step();
    check("done_pulse", done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    reset = 0;
    check("rst_seq_busy", seq_busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_run", dut_run, 0);
    check("rst_valid", res_valid, 0);
    check("rst_cycles", compute_cycles, 0);
    check("rst_addr", rd_address, 0);
    res_ready = 1;
    // basic round, plus a start during the round that must be ignored
    pops = 0;
    start_round(12'h000, 12'd1);
    fork
      busy_model(2, 100);
      wait_done(400);
      begin
        repeat (20) step();
        base_addr = 12'h123;
        num_results = 12'd5;
        start = 1;
        step();
        start = 0;
      end
    join
    check("t1_cycles", compute_cycles, 102);
    check("t1_words", pops, 1);
    check("t1_left", exp_q.size(), 0);
    check("t1_valid", res_valid, 0);
    // streaming, with busy already high before the run request
    dut_busy = 1;
    pops = 0;
    start_round(12'h0F8, 12'd8);
    repeat (5) step();
    check("t2_norun", dut_run, 0);
    check("t2_seq_busy", seq_busy, 1);
    dut_busy = 0;
    fork
      busy_model(3, 10);
      wait_done(300);
    join
    check("t2_words", pops, 8);
    check("t2_span", last_pop - first_pop, 7);
    // backpressure and address wrap
    pops = 0;
    start_round(12'hFFE, 12'd4);
    fork
      busy_model(1, 5);
      wait_done(300);
      begin
        int i = 0;
        while (seq_busy && i < 300) begin
          res_ready = (i % 3 == 0);
          step();
          i++;
        end
        res_ready = 1;
      end
    join
    check("t3_words", pops, 4);
    check("t3_left", exp_q.size(), 0);
    // watchdog timeout on the short-timeout instance
    begin
      int k = 0, len = 0;
      t_start = 1;
      step();
      t_start = 0;
      while (!t_dut_run && k < 20) begin
        step();
        k++;
      end
      check("t4_run_rise", t_dut_run, 1);
      while (t_dut_run && len < 100) begin
        step();
        len++;
      end
      check("t4_run_len", len, 17);
      check("t4_done", t_done, 1);
      check("t4_err", t_timeout_err, 1);
      step();
      check("t4_err_sticky", t_timeout_err, 1);
      t_start = 1;
      step();
      t_start = 0;
      check("t4_err_clear", t_timeout_err, 0);
      k = 0;
      while (!t_done && k < 100) begin
        step();
        k++;
      end
      check("t4_done2", t_done, 1);
    end
    // reset in the middle of readback, then an empty round
    pops = 0;
    start_round(12'h100, 12'd6);
    fork
      busy_model(1, 5);
      begin
        int k = 0;
        while (pops < 2 && k < 300) begin
          step();
          k++;
        end
        check("t5_two", pops, 2);
        reset = 1;
        step();
        reset = 0;
        check("t5_idle", seq_busy, 0);
        check("t5_valid", res_valid, 0);
        check("t5_run", dut_run, 0);
      end
    join
    exp_q.delete();
    pops = 0;
    start_round(12'h200, 12'd0);
    fork
      busy_model(1, 5);
      wait_done(100);
    join
    check("t5_no_words", pops, 0);
`ifdef GOLDEN_CMP_EN
    // golden compare with one corrupted golden word
    gold_bad = 12'h043;
    gold_bad_en = 1;
    pops = 0;
    start_round(12'h040, 12'd8);
    fork
      busy_model(1, 5);
      wait_done(300);
    join
    check("t6_words", pops, 8);
    check("t6_match", match_count, 7);
    gold_bad_en = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
